fsm_stream_decoder: RTL and testbench



---
 rtl/fsm_code_pkg.sv | 32 +++
 rtl/code_state_tracker.sv | 33 +++
 rtl/fsm_stream_decoder.sv | 99 +++++++++
 tb/tb_fsm_stream_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_code_pkg.sv
// Shared definitions for the 4-state Mealy line code: state encodings,
// transition function and the XOR-in-S3 coding rule. The encoder and the
// decoder both import this package so the two ends of the link stay in step.
package fsm_code_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } code_state_t;

  // Transition table shared by both ends of the link, driven by the source bit x.
  function automatic code_state_t next_state(input code_state_t s, input logic x);
    code_state_t n;
    case (s)
      S0:      n = x ? S1 : S2;
      S1:      n = x ? S3 : S2;
      S2:      n = x ? S3 : S1;
      S3:      n = x ? S0 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

  // The code inverts the bit only in S3. XOR is its own inverse, so the same
  // function maps x->y on the encoder side and y->x on the decoder side.
  function automatic logic code_bit(input code_state_t s, input logic b);
    return b ^ (s == S3);
  endfunction

endpackage

// File: rtl/code_state_tracker.sv
// Decoder-side copy of the encoder state machine. It recovers the source bit
// from the coded bit and advances on each accepted bit; resync realigns it
// to S0 before any coincident bit is decoded.
module code_state_tracker
  import fsm_code_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        resync,
  input  logic        in_bit,
  output logic        x,
  output code_state_t state
);

  code_state_t from_state;

  // A resync in the same cycle as a bit means that bit is decoded from S0.
  assign from_state = resync ? S0 : state;
  assign x          = code_bit(from_state, in_bit);

  // State register: advance on accept, realign on a bare resync, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
    end else if (accept) begin
      state <= next_state(from_state, x);
    end else if (resync) begin
      state <= S0;
    end
  end

endmodule

// File: rtl/fsm_stream_decoder.sv
// Receive end of the 4-state Mealy line code. Tracks the encoder state,
// recovers source bits, assembles them into W-bit words and hands words
// downstream over a valid/ready handshake.
module fsm_stream_decoder
  import fsm_code_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  input  logic         resync,
  output logic         dec_valid,
  output logic         dec_bit,
  output logic         out_valid,
  output logic [W-1:0] out_word,
  input  logic         out_ready,
  output logic [1:0]   state_dbg
);

  localparam int unsigned   CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  code_state_t   state;
  logic          x;
  logic          accept;
  logic          last_bit;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  logic [CW-1:0] pos;
  logic [W-1:0]  shreg;
  logic [W-1:0]  word_next;

  // Stall only the W-th bit while a word is still pending; this uses registered
  // state alone, so out_ready never reaches in_ready combinationally.
  assign in_ready = !((cnt == LAST) && out_valid);
  assign accept   = in_valid && in_ready;

  // resync restarts the word boundary before the coincident bit is placed.
  assign cnt_eff  = resync ? '0 : cnt;
  assign last_bit = (cnt_eff == LAST);

  assign state_dbg = state;

  code_state_tracker u_tracker (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .resync (resync),
    .in_bit (in_bit),
    .x      (x),
    .state  (state)
  );

  // Partial word with the current recovered bit merged in at its slot.
  always_comb begin
    pos       = LSB_FIRST ? cnt_eff : (LAST - cnt_eff);
    word_next = resync ? '0 : shreg;
    word_next[pos] = x;
  end

  // Word assembly, per-bit strobe and output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      dec_valid <= 1'b0;
      dec_bit   <= 1'b0;
    end else begin
      dec_valid <= accept;
      if (accept) begin
        dec_bit <= x;
      end
      if (accept && last_bit) begin
        out_word  <= word_next;
        out_valid <= 1'b1;
        cnt       <= '0;
        shreg     <= '0;
      end else begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
        if (accept) begin
          shreg <= word_next;
          cnt   <= cnt_eff + CW'(1);
        end else if (resync) begin
          shreg <= '0;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_stream_decoder.sv
// Bench for fsm_stream_decoder: directed scenarios followed by a random
// phase, all checked against a bit-queue reference model of the line code.
module tb_fsm_stream_decoder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_bit, resync, out_ready;
  logic         in_ready, dec_valid, dec_bit, out_valid;
  logic [W-1:0] out_word;
  logic [1:0]   state_dbg;
  logic         in_ready_m, dec_valid_m, dec_bit_m, out_valid_m;
  logic [W-1:0] out_word_m;
  logic [1:0]   state_dbg_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_stream_decoder #(.W(W), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .resync(resync), .dec_valid(dec_valid),
    .dec_bit(dec_bit), .out_valid(out_valid), .out_word(out_word),
    .out_ready(out_ready), .state_dbg(state_dbg)
  );

  fsm_stream_decoder #(.W(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_m), .resync(resync), .dec_valid(dec_valid_m),
    .dec_bit(dec_bit_m), .out_valid(out_valid_m), .out_word(out_word_m),
    .out_ready(out_ready), .state_dbg(state_dbg_m)
  );

  // Reference model: state as an integer walked through a lookup table,
  // the partial word as a queue of recovered bits.
  int           nxt [4][2];
  int           m_state;
  logic         m_bits [$];
  logic         m_ov, m_dv, m_db, m_acc;
  logic [W-1:0] m_wl, m_wm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bits.delete();
    m_ov = 0; m_dv = 0; m_db = 0; m_acc = 0; m_wl = '0; m_wm = '0;
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input logic iv, input logic y, input logic rs,
                      input logic ordy, input logic rst);
    logic rdy, xb;
    in_valid = iv; in_bit = y; resync = rs; out_ready = ordy; reset = rst;
    #1;
    rdy = !((m_bits.size() == W - 1) && m_ov);
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("in_ready_msb", {31'd0, in_ready_m}, {31'd0, rdy});
    @(posedge clk); #1;
    m_acc = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (rs) begin m_state = 0; m_bits.delete(); end
      if (iv && rdy) begin
        m_acc = 1;
        xb = y ^ (m_state == 3);
        m_state = nxt[m_state][xb];
        m_bits.push_back(xb);
        m_dv = 1; m_db = xb;
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            m_wl[i]       = m_bits[i];
            m_wm[W-1-i]   = m_bits[i];
          end
          m_ov = 1;
          m_bits.delete();
        end else if (m_ov && ordy) begin
          m_ov = 0;
        end
      end else begin
        m_dv = 0;
        if (m_ov && ordy) m_ov = 0;
      end
    end
    chk("state_dbg", {30'd0, state_dbg}, m_state);
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_dv});
    chk("dec_bit", {31'd0, dec_bit}, {31'd0, m_db});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_word", {24'd0, out_word}, {24'd0, m_wl});
    chk("out_valid_msb", {31'd0, out_valid_m}, {31'd0, m_ov});
    chk("out_word_msb", {24'd0, out_word_m}, {24'd0, m_wm});
  endtask

  // Present a bit and hold it until accepted; resync applies to the first attempt only.
  task automatic send(input logic y, input logic rs, input logic ordy);
    logic r;
    r = rs;
    for (int t = 0; t < 40; t++) begin
      step(1'b1, y, r, ordy, 1'b0);
      r = 1'b0;
      if (m_acc) return;
    end
    n_tests++; n_fail++;
    $display("FAIL send_timeout observed=stalled expected=accepted");
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  logic [7:0] seq_y;
  logic [7:0] seq_x;
  logic [W-1:0] saved;

  initial begin
    nxt = '{'{2, 1}, '{2, 3}, '{1, 3}, '{2, 0}};
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; resync = 1'b0; out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_word", {24'd0, out_word}, 0);
    chk("rst_state", {30'd0, state_dbg}, 0);
    chk("rst_dec_bit", {31'd0, dec_bit}, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // Stream y=1,0,1,0,0,0,1,1 -> x=1,0,1,1,0,0,1,0, word 0x4D, ends in S2
    seq_y = 8'b1100_0101;
    seq_x = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      send(seq_y[i], 1'b0, 1'b1);
      chk("seq_dec_bit", {31'd0, dec_bit}, {31'd0, seq_x[i]});
    end
    chk("seq_word", {24'd0, out_word}, 32'h4D);
    chk("seq_valid", {31'd0, out_valid}, 1);
    chk("seq_state", {30'd0, state_dbg}, 2);
    idle(1'b1);
    chk("seq_valid_pulse", {31'd0, out_valid}, 0);

    // Eight ones from reset -> 0xAB (LSB first) and 0xD5 (MSB first)
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 1'b1);
    chk("ones_lsb", {24'd0, out_word}, 32'hAB);
    chk("ones_msb", {24'd0, out_word_m}, 32'hD5);

    // Backpressure: word 1 pending, 7 more bits fill to cnt==7, 16th stalls
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    saved = out_word;
    for (int i = 0; i < 7; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("bp_in_ready_low", {31'd0, in_ready}, 0);
    in_bit = 1'($urandom_range(0, 1));
    step(1'b1, in_bit, 1'b0, 1'b0, 1'b0);
    step(1'b1, in_bit, 1'b0, 1'b0, 1'b0);
    chk("bp_stall_dec_valid", {31'd0, dec_valid}, 0);
    chk("bp_word_held", {24'd0, out_word}, {24'd0, saved});
    step(1'b1, in_bit, 1'b0, 1'b1, 1'b0);
    chk("bp_consumed", {31'd0, out_valid}, 0);
    step(1'b1, in_bit, 1'b0, 1'b0, 1'b0);
    chk("bp_word2_valid", {31'd0, out_valid}, 1);
    chk("bp_16th_accepted", {31'd0, dec_valid}, 1);

    // resync coincident with the 4th bit (y=1 -> x=1 from S0, bit 0 of new word)
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b1);
    chk("rs_dec_bit", {31'd0, dec_bit}, 1);
    chk("rs_state", {30'd0, state_dbg}, 1);
    for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("rs_no_early_word", {31'd0, out_valid}, 0);
    send(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("rs_word_valid", {31'd0, out_valid}, 1);
    saved = out_word;
    chk("rs_bit0", {31'd0, saved[0]}, 1);

    // Consume on the same cycle as the next word's final bit arrives
    for (int i = 0; i < 7; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    send(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("cl_valid", {31'd0, out_valid}, 1);

    // Reset mid-word with a pending word; no edge -> no change
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    saved = {6'd0, state_dbg};
    reset = 1'b1;
    #2;
    chk("rst_noedge_valid", {31'd0, out_valid}, 1);
    chk("rst_noedge_state", {30'd0, state_dbg}, {24'd0, saved});
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_valid", {31'd0, out_valid}, 0);
    chk("rst_mid_state", {30'd0, state_dbg}, 0);
    chk("rst_mid_dec_valid", {31'd0, dec_valid}, 0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
